// File: rtl/risc16_program_loader_pkg.sv
// rtl/risc16_program_loader_pkg.sv - shared types and constants for the RiSC-16 program loader (LOADER_CHECKSUM_EN adds checksum states)
`ifndef RISC16_WORD
`define RISC16_WORD 16
`endif

package risc16_program_loader_pkg;

  localparam int WORD_W = `RISC16_WORD;
  localparam int BYTE_W = 8;

  // Frame byte order on the wire: high byte first, low byte second.
  localparam int HI_LSB = 8;
  localparam int LO_LSB = 0;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_LEN_HI  = 4'd1,
    ST_LEN_LO  = 4'd2,
    ST_CHECK   = 4'd3,
    ST_DATA_HI = 4'd4,
    ST_DATA_LO = 4'd5,
    ST_WRITE   = 4'd6,
    ST_DONE    = 4'd7,
    ST_ERROR   = 4'd8,
    ST_CSUM_HI = 4'd9,
    ST_CSUM_LO = 4'd10
  } loader_state_t;

  // Assemble a big-endian word from its two wire bytes.
  function automatic logic [WORD_W-1:0] be_word(input logic [BYTE_W-1:0] hi,
                                                input logic [BYTE_W-1:0] lo);
    logic [WORD_W-1:0] w;
    w = '0;
    w[HI_LSB +: BYTE_W] = hi;
    w[LO_LSB +: BYTE_W] = lo;
    return w;
  endfunction

endpackage

// File: rtl/risc16_program_loader_if.sv
// rtl/risc16_program_loader_if.sv - byte stream and instruction memory write bus of the program loader
interface risc16_program_loader_if #(
  parameter int ADDR_WIDTH = 16
);
  logic [7:0]            byte_in;
  logic                  byte_valid;
  logic                  byte_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [15:0]           mem_data;
  logic                  mem_wen;

  // Loader side: consumes the byte stream, drives the memory write port.
  modport master (
    input  byte_in,
    input  byte_valid,
    output byte_ready,
    output mem_addr,
    output mem_data,
    output mem_wen
  );

  // Environment side: produces the byte stream, observes memory writes.
  modport slave (
    output byte_in,
    output byte_valid,
    input  byte_ready,
    input  mem_addr,
    input  mem_data,
    input  mem_wen
  );
endinterface

// File: rtl/risc16_program_loader_csum.sv
// rtl/risc16_program_loader_csum.sv - running mod-2^16 sum of loaded words, built only with LOADER_CHECKSUM_EN
`ifdef LOADER_CHECKSUM_EN
module risc16_program_loader_csum
  import risc16_program_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              add,
  input  logic [WORD_W-1:0] word,
  output logic [WORD_W-1:0] value
);

  // Accumulate each written word; cleared when a new load starts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (add) begin
      value <= value + word;
    end
  end

endmodule
`endif

// File: rtl/risc16_program_loader.sv
// rtl/risc16_program_loader.sv - framed byte-stream loader for RiSC-16 instruction memory; LOADER_CHECKSUM_EN enables trailing checksum
module risc16_program_loader
  import risc16_program_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int MEM_SIZE   = 65536,
  parameter int BASE_ADDR  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  risc16_program_loader_if.master bus,
  output logic                    cpu_hold,
  output logic                    done,
  output logic                    error,
  output logic [ADDR_WIDTH-1:0]   word_count
);

  // Words that fit between BASE_ADDR and the top of memory; bounds N so mem_addr never wraps mid-image.
  localparam logic [31:0]           AVAIL_WORDS = 32'(MEM_SIZE - BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] BASE        = ADDR_WIDTH'(BASE_ADDR);

  loader_state_t state, state_next;

  logic [BYTE_W-1:0]     len_hi_q;
  logic [WORD_W-1:0]     len_q;
  logic [WORD_W-1:0]     words_left_q;
  logic [WORD_W-1:0]     mem_data_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  byte_ready;
  logic                  mem_wen;
  logic                  take;
  logic                  loading;
  logic                  last_word;
  logic                  oversize;

  assign take      = bus.byte_valid && byte_ready;
  assign loading   = state inside {ST_LEN_HI, ST_LEN_LO, ST_CHECK, ST_DATA_HI,
                                   ST_DATA_LO, ST_WRITE, ST_CSUM_HI, ST_CSUM_LO};
  assign last_word = (words_left_q == WORD_W'(1));
  assign oversize  = ({16'd0, len_q} > AVAIL_WORDS);

  assign bus.byte_ready = byte_ready;
  assign bus.mem_wen    = mem_wen;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_data   = mem_data_q;

`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_t ST_AFTER_DATA = ST_CSUM_HI;

  logic [BYTE_W-1:0] csum_hi_q;
  logic [WORD_W-1:0] csum_value;
  logic              csum_match;

  risc16_program_loader_csum u_csum (
    .clk   (clk),
    .rst   (rst),
    .clear (state == ST_IDLE && start),
    .add   (mem_wen),
    .word  (mem_data_q),
    .value (csum_value)
  );

  assign csum_match = (be_word(csum_hi_q, bus.byte_in) == csum_value);

  // Hold the high checksum byte until the low byte arrives for comparison.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csum_hi_q <= '0;
    end else if (take && state == ST_CSUM_HI) begin
      csum_hi_q <= bus.byte_in;
    end
  end
`else
  localparam loader_state_t ST_AFTER_DATA = ST_DONE;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and per-state strobes; a dropped start aborts any loading state.
  always_comb begin
    state_next = state;
    byte_ready = 1'b0;
    mem_wen    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        byte_ready = 1'b1;
        if (!start)               state_next = ST_IDLE;
        else if (bus.byte_valid)  state_next = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        byte_ready = 1'b1;
        if (!start)               state_next = ST_IDLE;
        else if (bus.byte_valid)  state_next = ST_CHECK;
      end
      ST_CHECK: begin
        if (!start)               state_next = ST_IDLE;
        else if (len_q == '0)     state_next = ST_AFTER_DATA;
        else if (oversize)        state_next = ST_ERROR;
        else                      state_next = ST_DATA_HI;
      end
      ST_DATA_HI: begin
        byte_ready = 1'b1;
        if (!start)               state_next = ST_IDLE;
        else if (bus.byte_valid)  state_next = ST_DATA_LO;
      end
      ST_DATA_LO: begin
        byte_ready = 1'b1;
        if (!start)               state_next = ST_IDLE;
        else if (bus.byte_valid)  state_next = ST_WRITE;
      end
      ST_WRITE: begin
        mem_wen = 1'b1;
        if (!start)               state_next = ST_IDLE;
        else if (last_word)       state_next = ST_AFTER_DATA;
        else                      state_next = ST_DATA_HI;
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CSUM_HI: begin
        byte_ready = 1'b1;
        if (!start)               state_next = ST_IDLE;
        else if (bus.byte_valid)  state_next = ST_CSUM_LO;
      end
      ST_CSUM_LO: begin
        byte_ready = 1'b1;
        if (!start)               state_next = ST_IDLE;
        else if (bus.byte_valid)  state_next = csum_match ? ST_DONE : ST_ERROR;
      end
`endif
      ST_DONE, ST_ERROR: begin
        if (!start) state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Status flags, frame length, assembled word and write address/count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_hold     <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      word_count   <= '0;
      mem_addr_q   <= BASE;
      mem_data_q   <= '0;
      len_hi_q     <= '0;
      len_q        <= '0;
      words_left_q <= '0;
    end else begin
      if (state == ST_IDLE && start) begin
        cpu_hold   <= 1'b1;
        done       <= 1'b0;
        error      <= 1'b0;
        word_count <= '0;
        mem_addr_q <= BASE;
      end else if (loading && !start) begin
        cpu_hold <= 1'b0;
        error    <= 1'b1;
      end else if (state_next == ST_DONE && state != ST_DONE) begin
        cpu_hold <= 1'b0;
        done     <= 1'b1;
      end else if (state_next == ST_ERROR && state != ST_ERROR) begin
        cpu_hold <= 1'b0;
        error    <= 1'b1;
      end

      if (take && state == ST_LEN_HI) len_hi_q <= bus.byte_in;
      if (take && state == ST_LEN_LO) len_q    <= be_word(len_hi_q, bus.byte_in);
      if (take && state == ST_DATA_HI) mem_data_q[HI_LSB +: BYTE_W] <= bus.byte_in;
      if (take && state == ST_DATA_LO) mem_data_q[LO_LSB +: BYTE_W] <= bus.byte_in;

      if (state == ST_CHECK) words_left_q <= len_q;

      // A write in flight completes even when start falls in the same cycle.
      if (mem_wen) begin
        mem_addr_q   <= mem_addr_q + ADDR_WIDTH'(1);
        word_count   <= word_count + ADDR_WIDTH'(1);
        words_left_q <= words_left_q - WORD_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_risc16_program_loader.sv
// tb/tb_risc16_program_loader.sv - self-checking bench for risc16_program_loader (LOADER_CHECKSUM_EN adds checksum frames)
module tb_risc16_program_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        cpu_hold, done, error;
  logic [15:0] word_count;
  logic        h_cpu_hold, h_done, h_error;
  logic [15:0] h_word_count;

  risc16_program_loader_if #(.ADDR_WIDTH(16)) bus ();
  risc16_program_loader_if #(.ADDR_WIDTH(16)) hbus ();

  assign bus.byte_in     = byte_in;
  assign bus.byte_valid  = byte_valid;
  assign hbus.byte_in    = byte_in;
  assign hbus.byte_valid = byte_valid;

  risc16_program_loader #(.ADDR_WIDTH(16), .MEM_SIZE(65536), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .cpu_hold(cpu_hold), .done(done), .error(error), .word_count(word_count)
  );

  risc16_program_loader #(.ADDR_WIDTH(16), .MEM_SIZE(65536), .BASE_ADDR(32'hFFFE)) hdut (
    .clk(clk), .rst(rst), .start(start), .bus(hbus),
    .cpu_hold(h_cpu_hold), .done(h_done), .error(h_error), .word_count(h_word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n;
    int gap_max;
    bit exp_done;
    bit exp_err;
    int exp_wr;
    bit h_done;
    bit h_err;
    int h_wr;
  } vec_t;

  vec_t        vecs [7];
  int          n_checks = 0;
  int          n_pass = 0;
  int          rdy_in_write = 0;
  logic [15:0] frame_words [$];
  logic [15:0] csum_bias = 16'h0000;
  logic [15:0] cap_addr [$];
  logic [15:0] cap_data [$];
  logic [15:0] hcap_addr [$];
  logic [15:0] hcap_data [$];
  logic [7:0]  basic_bytes [6] = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
  bit          bs_rdy [10] = '{0, 1, 1, 0, 1, 1, 0, 1, 1, 0};
  bit          bs_wen [10] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 1};

  always @(negedge clk) begin
    if (bus.mem_wen) begin
      cap_addr.push_back(bus.mem_addr);
      cap_data.push_back(bus.mem_data);
      if (bus.byte_ready) rdy_in_write++;
    end
    if (hbus.mem_wen) begin
      hcap_addr.push_back(hbus.mem_addr);
      hcap_data.push_back(hbus.mem_data);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic clear_caps();
    cap_addr.delete(); cap_data.delete();
    hcap_addr.delete(); hcap_data.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard = 0;
    if (gap > 0) begin
      byte_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    byte_in = b;
    byte_valid = 1'b1;
    while (!bus.byte_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) chk("byte_ready_timeout", 32'(guard), 0);
    @(negedge clk);
  endtask

  task automatic wait_finish(input string tag);
    int t = 0;
    while (!(done || error) && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_finish"}, 32'(t < 400), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic idle_out();
    start = 1'b0;
    byte_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Reference: word i of an accepted image lands at base+i; a rejected image writes nothing.
  task automatic check_writes(input string tag, input bit hi, input int exp_n);
    int sz;
    logic [15:0] base;
    base = hi ? 16'hFFFE : 16'h0000;
    sz = hi ? hcap_addr.size() : cap_addr.size();
    chk({tag, "_nwrites"}, 32'(sz), 32'(exp_n));
    for (int i = 0; i < sz && i < exp_n; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), hi ? hcap_addr[i] : cap_addr[i], 16'(base + 16'(i)));
      chk($sformatf("%s_data%0d", tag, i), hi ? hcap_data[i] : cap_data[i], frame_words[i]);
    end
  endtask

  task automatic run_load(input int n, input int gap_max);
    logic [15:0] sum;
    logic [15:0] len;
    sum = 16'h0000;
    len = 16'(n);
    clear_caps();
    @(negedge clk);
    start = 1'b1;
    byte_valid = 1'b0;
    @(negedge clk);
    chk("hold_rise", cpu_hold, 1);
    chk("done_clear", done, 0);
    chk("err_clear", error, 0);
    chk("wc_clear", word_count, 0);
    send_byte(len[15:8], $urandom_range(gap_max, 0));
    send_byte(len[7:0], $urandom_range(gap_max, 0));
    for (int i = 0; i < n; i++) begin
      send_byte(frame_words[i][15:8], $urandom_range(gap_max, 0));
      send_byte(frame_words[i][7:0], $urandom_range(gap_max, 0));
      sum = sum + frame_words[i];
    end
`ifdef LOADER_CHECKSUM_EN
    sum = sum + csum_bias;
    send_byte(sum[15:8], $urandom_range(gap_max, 0));
    send_byte(sum[7:0], $urandom_range(gap_max, 0));
`endif
    byte_valid = 1'b0;
    wait_finish("load");
  endtask

  initial begin
    int  idx;
    bit  prev_rdy;
    vecs[0] = '{0,  0, 1, 0, 0,  1, 0, 0};
    vecs[1] = '{1,  0, 1, 0, 1,  1, 0, 1};
    vecs[2] = '{2,  3, 1, 0, 2,  1, 0, 2};
    vecs[3] = '{3,  0, 1, 0, 3,  0, 1, 0};
    vecs[4] = '{5,  2, 1, 0, 5,  0, 1, 0};
    vecs[5] = '{9,  5, 1, 0, 9,  0, 1, 0};
    vecs[6] = '{16, 0, 1, 0, 16, 0, 1, 0};

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_ready", bus.byte_ready, 0);
    chk("rst_addr", bus.mem_addr, 16'h0000);
    chk("rst_haddr", hbus.mem_addr, 16'hFFFE);
    chk("rst_data", bus.mem_data, 0);
    chk("rst_wen", bus.mem_wen, 0);
    chk("rst_hold", cpu_hold, 0);
    chk("rst_done", done, 0);
    chk("rst_err", error, 0);
    chk("rst_wc", word_count, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Basic load at full rate with cycle-exact ready/write strobes.
    frame_words.delete();
    frame_words.push_back(16'h1234);
    frame_words.push_back(16'hABCD);
    clear_caps();
    start = 1'b1;
    byte_valid = 1'b1;
    idx = 0;
    byte_in = basic_bytes[0];
    prev_rdy = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (prev_rdy) begin
        idx++;
        if (idx < 6) byte_in = basic_bytes[idx];
        else byte_valid = 1'b0;
      end
      chk($sformatf("basic_rdy_c%0d", c), bus.byte_ready, bs_rdy[c]);
      chk($sformatf("basic_wen_c%0d", c), bus.mem_wen, bs_wen[c]);
      prev_rdy = bus.byte_ready;
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'hBE, 0);
    send_byte(8'h01, 0);
    byte_valid = 1'b0;
`endif
    wait_finish("basic");
    chk("basic_done", done, 1);
    chk("basic_hold", cpu_hold, 0);
    chk("basic_wc", word_count, 2);
    check_writes("basic", 1'b0, 2);
    check_writes("basic_hi", 1'b1, 2);
    chk("basic_hi_done", h_done, 1);
    idle_out();

    // Table-driven loads with random words and random byte gaps.
    for (int v = 0; v < 7; v++) begin
      frame_words.delete();
      for (int i = 0; i < vecs[v].n; i++) frame_words.push_back(16'($urandom));
      csum_bias = 16'h0000;
      run_load(vecs[v].n, vecs[v].gap_max);
      chk($sformatf("v%0d_done", v), done, vecs[v].exp_done);
      chk($sformatf("v%0d_err", v), error, vecs[v].exp_err);
      chk($sformatf("v%0d_hold", v), cpu_hold, 0);
      chk($sformatf("v%0d_wc", v), word_count, 32'(vecs[v].exp_wr));
      check_writes($sformatf("v%0d", v), 1'b0, vecs[v].exp_wr);
      chk($sformatf("v%0d_hdone", v), h_done, vecs[v].h_done);
      chk($sformatf("v%0d_herr", v), h_error, vecs[v].h_err);
      chk($sformatf("v%0d_hhold", v), h_cpu_hold, 0);
      chk($sformatf("v%0d_hwc", v), h_word_count, 32'(vecs[v].h_wr));
      check_writes($sformatf("v%0d_hi", v), 1'b1, vecs[v].h_wr);
      idle_out();
      chk($sformatf("v%0d_sticky", v), done, vecs[v].exp_done);
      chk($sformatf("v%0d_idle_rdy", v), bus.byte_ready, 0);
    end

    // Abort after the HI byte of word 1 of a 4-word load.
    frame_words.delete();
    for (int i = 0; i < 4; i++) frame_words.push_back(16'($urandom));
    clear_caps();
    @(negedge clk);
    start = 1'b1;
    byte_valid = 1'b0;
    @(negedge clk);
    send_byte(8'h00, 0);
    send_byte(8'h04, 0);
    send_byte(frame_words[0][15:8], 1);
    send_byte(frame_words[0][7:0], 0);
    send_byte(frame_words[1][15:8], 0);
    start = 1'b0;
    byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_writes("abort", 1'b0, 1);
    chk("abort_err", error, 1);
    chk("abort_done", done, 0);
    chk("abort_hold", cpu_hold, 0);
    chk("abort_idle_rdy", bus.byte_ready, 0);
    chk("abort_wc", word_count, 1);

    // start falling during WRITE still completes that write.
    clear_caps();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(frame_words[0][15:8], 0);
    send_byte(frame_words[0][7:0], 0);
    start = 1'b0;
    byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_writes("wabort", 1'b0, 1);
    chk("wabort_err", error, 1);
    chk("wabort_wc", word_count, 1);

    // Reset pulse mid-load.
    clear_caps();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    send_byte(frame_words[0][15:8], 0);
    send_byte(frame_words[0][7:0], 0);
    #1 rst = 1'b0;
    #1;
    chk("mrst_ready", bus.byte_ready, 0);
    chk("mrst_addr", bus.mem_addr, 0);
    chk("mrst_data", bus.mem_data, 0);
    chk("mrst_wen", bus.mem_wen, 0);
    chk("mrst_hold", cpu_hold, 0);
    chk("mrst_err", error, 0);
    chk("mrst_wc", word_count, 0);
    start = 1'b0;
    byte_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("mrst_nwrites", 32'(cap_addr.size()), 1);

`ifdef LOADER_CHECKSUM_EN
    frame_words.delete();
    frame_words.push_back(16'h0001);
    frame_words.push_back(16'hFFFF);
    csum_bias = 16'h0000;
    run_load(2, 0);
    chk("csum_ok_done", done, 1);
    chk("csum_ok_err", error, 0);
    idle_out();
    csum_bias = 16'h0001;
    run_load(2, 1);
    chk("csum_bad_done", done, 0);
    chk("csum_bad_err", error, 1);
    idle_out();
`endif

    chk("ready_low_in_write", 32'(rdy_in_write), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/risc16_program_loader.md
# risc16_program_loader

Byte-stream program loader that sits directly upstream of the RiSC-16 instruction memory. It accepts a framed byte stream over a valid/ready handshake and assembles big-endian 16-bit instruction words. It drives sequential write address, data and write-enable into instruction memory, and holds the core stalled until the image is complete.

## Interface
Parameters:
- ADDR_WIDTH, 16, instruction memory address width.
- MEM_SIZE, 65536, number of instruction memory words.
- BASE_ADDR, 0, address of the first loaded word.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  load request (program enable); level-sensitive, must stay high for the whole load.
- byte_in  input  8  stream byte.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader accepts byte this cycle.
- mem_addr  output  ADDR_WIDTH  instruction memory write address.
- mem_data  output  16  instruction memory write data.
- mem_wen  output  1  instruction memory write enable, one-cycle pulse per word.
- cpu_hold  output  1  core stall/reset request while loading.
- done  output  1  image loaded successfully; sticky until next start.
- error  output  1  load failed; sticky until next start.
- word_count  output  ADDR_WIDTH  words written so far in current load.

## Operation
- Frame: LEN_HI, LEN_LO (16-bit word count N, big-endian), then N words as HI, LO byte pairs.
- A byte is accepted on a posedge with byte_valid && byte_ready.
- States: IDLE, LEN_HI, LEN_LO, CHECK, DATA_HI, DATA_LO, WRITE, DONE, ERROR.
- IDLE: byte_ready=0. start=1 moves the FSM to LEN_HI, clears done, error and word_count, sets cpu_hold=1, and sets mem_addr=BASE_ADDR.
- LEN_HI/LEN_LO: latch the length bytes. CHECK (one cycle, byte_ready=0) evaluates N:
  - N==0 -> DONE with no writes.
  - N > MEM_SIZE-BASE_ADDR -> ERROR.
  - Otherwise -> DATA_HI.
- DATA_HI latches mem_data[15:8]. DATA_LO latches mem_data[7:0] and moves to WRITE.
- WRITE: mem_wen=1 for exactly one cycle and byte_ready=0. On exit, mem_addr and word_count each increment by 1. If word_count+1==N, go to DONE; otherwise go to DATA_HI.
- DONE: cpu_hold=0, done=1. Stay in DONE while start=1; go to IDLE when start=0. done remains set.
- ERROR: cpu_hold=0, error=1. Leave on start=0, as for DONE.
- Abort: start falling in any state from LEN_HI to WRITE goes to IDLE with error=1 and cpu_hold=0. If the fall coincides with WRITE, that write still completes.
- Address arithmetic is unsigned ADDR_WIDTH. The length check guarantees mem_addr never wraps.

## Timing
- Reset values: byte_ready=0, mem_addr=BASE_ADDR, mem_data=0, mem_wen=0, cpu_hold=0, done=0, error=0, word_count=0, FSM=IDLE.
- Reset mid-load aborts immediately, with no further writes.
- start is sampled at posedge. cpu_hold rises the cycle after start is first seen high.
- byte_ready is combinational from state: high in LEN_HI, LEN_LO, DATA_HI and DATA_LO, low otherwise.
- Latency: mem_wen pulses on the cycle after the LO byte handshake. mem_addr/mem_data are stable for that whole cycle.
- Peak throughput: 1 word per 3 cycles.
- Back-to-back valid bytes are accepted without bubbles, except in the CHECK and WRITE cycles.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - The frame carries a trailing 16-bit big-endian checksum after the last word, equal to the sum mod 2^16 of all N words.
  - The FSM adds states CSUM_HI and CSUM_LO after the final WRITE. N==0 also goes through them, with an expected checksum of 0.
  - Mismatch -> ERROR; match -> DONE.
- Not defined: no checksum bytes are read, and DONE follows the last WRITE directly.

## Structure
- Shared package/defines file: FSM state encodings, the frame byte-order constants, and a `RISC16_WORD` width constant.
- No sub-module is required. An optional `risc16_loader_csum` accumulator (clear/add/value) is natural when LOADER_CHECKSUM_EN is set.

## Test plan
- Basic load: start=1, bytes 00 02 12 34 AB CD -> two mem_wen pulses: addr 0 data 0x1234, then addr 1 data 0xABCD. done=1, cpu_hold=0, word_count=2.
- Zero length: start=1, bytes 00 00 -> no mem_wen, done=1. With LOADER_CHECKSUM_EN, also send 00 00.
- Oversize: BASE_ADDR=0xFFFE, N=3 -> ERROR, error=1, no writes.
- Abort: start dropped after the HI byte of word 1 in a 4-word load -> exactly 1 write, error=1, FSM back in IDLE.
- Backpressure and gaps: random byte_valid gaps plus full-rate bursts -> identical memory contents; byte_ready is low in CHECK and WRITE.
- Checksum (macro on): words 0x0001, 0xFFFF with checksum 0x0000 -> done=1. Same words with checksum 0x0001 -> error=1. An rst pulse mid-load resets every output to its reset value.
